rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 (execute/ALU) and req1 (memory/load).
- Grants requesters round-robin over valid/ready handshakes and drives a registered write port.
- Keeps a per-register pending-write scoreboard, which decode uses for RAW hazard stalls.
- Sits between the execute/memory stages and the 32-entry integer register file.

Parameters:
REGISTER_WIDTH, 5, register index width (32 architectural registers)
DATA_WIDTH, 64, register data width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  execute writeback request
req0_reg  input  REGISTER_WIDTH  destination register for req0
req0_data  input  DATA_WIDTH  write data for req0
req0_ready  output  1  req0 accepted this cycle when high together with req0_valid
req1_valid  input  1  memory writeback request
req1_reg  input  REGISTER_WIDTH  destination register for req1
req1_data  input  DATA_WIDTH  write data for req1
req1_ready  output  1  req1 accepted this cycle when high together with req1_valid
reserve_valid  input  1  decode issued an instruction that will write reserve_reg
reserve_reg  input  REGISTER_WIDTH  register being reserved
flush  input  1  pipeline flush; clears the scoreboard
query_rs1  input  REGISTER_WIDTH  decode source 1
query_rs2  input  REGISTER_WIDTH  decode source 2
hazard  output  1  query_rs1 or query_rs2 has a pending write
wr_en  output  1  register-file write enable
wr_reg  output  REGISTER_WIDTH  register-file write index
wr_data  output  DATA_WIDTH  register-file write data
busy  output  2**REGISTER_WIDTH  scoreboard vector; bit 0 is always 0

Behaviour:
- Reset: the clock is clk; the reset is reset, asynchronous and active-high. On reset, wr_en, wr_reg, wr_data, busy and prio all go to 0.
- prio is 1 bit and holds the requester that wins a conflict.
- Readiness is combinational and does not depend on the requester's own valid:
  - req0_ready = !req1_valid || prio==0
  - req1_ready = !req0_valid || prio==1
- The write port cannot stall, so at most one request is accepted per cycle.
- On an accept by requester i, prio becomes the other requester at the clock edge. With no accept, prio holds.
- Latency: an accept in cycle N produces wr_en/wr_reg/wr_data valid in cycle N+1.
  - With no accept, wr_en=0 in the next cycle; wr_reg and wr_data hold their last values.
- x0: a request with reg==0 is accepted normally (ready, prio update), but wr_en stays 0.
- Scoreboard:
  - busy[r] is set at the edge where reserve_valid && reserve_reg==r && r!=0.
  - busy[r] is cleared at the edge where a request to r is accepted.
  - Set and clear of the same register in the same cycle: set wins (a newer producer is in flight).
  - Reserve of x0 is ignored; busy[0] is constant 0.
- flush: all busy bits clear at the edge. Any reserve in the same cycle is still applied after the clear. Accepts and the write port are unaffected.
- hazard = (busy[query_rs1] && query_rs1!=0) || (busy[query_rs2] && query_rs2!=0). It is purely combinational from the registered busy, so a clear is visible the cycle after the accept.
- Mid-operation reset: the write issued in the reset cycle is lost and the scoreboard is emptied. Requesters must re-present.

Optional Feature:
- RF_WB_TRACE_EN:
  - When defined, every cycle with wr_en=1 prints time, requester id, register index, ABI name (via get_reg_name) and data with $display.
  - Every accept that wins a conflict (both valid) also prints a line.
  - When undefined, there is no simulation output; synthesized logic is identical in both cases.

Test Plan:
- Reset asserted async mid-cycle with busy=0xFF0 -> busy=0, wr_en=0 immediately, prio=0.
- req0 only: reg=5, data=0x1234 -> req0_ready=1; next cycle wr_en=1, wr_reg=5, wr_data=0x1234; busy[5] cleared.
- Both valid for 4 cycles from reset (req0 reg 3, req1 reg 7) -> grants 0,1,0,1; wr_reg sequence 3,7,3,7, each one cycle later.
- reserve reg 9, then query_rs2=9 -> hazard=1. Accept req1 reg 9 -> hazard=0 the following cycle. Same-cycle reserve 9 + accept 9 -> busy[9] stays 1.
- req0 reg 0 data 0xFF -> accepted, prio flips, wr_en stays 0. reserve_reg=0 -> busy unchanged, hazard=0 for query 0.
- busy bits 2,4 set; flush with reserve 6 in the same cycle -> busy has only bit 6 set.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: round-robin share of the single register-file write
// port between execute (req0) and memory (req1) writeback, plus a per-register
// pending-write scoreboard used by decode for RAW hazard detection.
// Optional build macro: RF_WB_TRACE_EN (simulation-only write/grant trace).
`default_nettype none

module rf_writeback_arbiter #(
  parameter int REGISTER_WIDTH = 5,
  parameter int DATA_WIDTH     = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_valid,
  input  logic [REGISTER_WIDTH-1:0]     req0_reg,
  input  logic [DATA_WIDTH-1:0]         req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [REGISTER_WIDTH-1:0]     req1_reg,
  input  logic [DATA_WIDTH-1:0]         req1_data,
  output logic                          req1_ready,
  input  logic                          reserve_valid,
  input  logic [REGISTER_WIDTH-1:0]     reserve_reg,
  input  logic                          flush,
  input  logic [REGISTER_WIDTH-1:0]     query_rs1,
  input  logic [REGISTER_WIDTH-1:0]     query_rs2,
  output logic                          hazard,
  output logic                          wr_en,
  output logic [REGISTER_WIDTH-1:0]     wr_reg,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [2**REGISTER_WIDTH-1:0]  busy
);

  localparam int NREG = 2**REGISTER_WIDTH;

  logic                      prio_q;
  logic                      acc0_p0;
  logic                      acc1_p0;
  logic                      wr_en_p1;
  logic [REGISTER_WIDTH-1:0] wr_reg_p1;
  logic [DATA_WIDTH-1:0]     wr_data_p1;
  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;

  // Readiness depends only on the other requester and the priority bit, so
  // at most one of the two can be accepted in any cycle.
  always_comb begin
    req0_ready = !req1_valid || (prio_q == 1'b0);
    req1_ready = !req0_valid || (prio_q == 1'b1);
    acc0_p0    = req0_valid && req0_ready;
    acc1_p0    = req1_valid && req1_ready;
  end

  // Scoreboard next state: flush or accept clears, then a reserve sets, so a
  // newer producer of the same register always survives.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else if (acc0_p0) begin
      busy_d[req0_reg] = 1'b0;
    end else if (acc1_p0) begin
      busy_d[req1_reg] = 1'b0;
    end
    if (reserve_valid && (reserve_reg != '0)) begin
      busy_d[reserve_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // ---- stage p0 -> p1: accepted request becomes the registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q     <= 1'b0;
      wr_en_p1   <= 1'b0;
      wr_reg_p1  <= '0;
      wr_data_p1 <= '0;
      busy_q     <= '0;
    end else begin
      busy_q   <= busy_d;
      wr_en_p1 <= (acc0_p0 && (req0_reg != '0)) || (acc1_p0 && (req1_reg != '0));
      if (acc0_p0) begin
        prio_q     <= 1'b1;
        wr_reg_p1  <= req0_reg;
        wr_data_p1 <= req0_data;
      end else if (acc1_p0) begin
        prio_q     <= 1'b0;
        wr_reg_p1  <= req1_reg;
        wr_data_p1 <= req1_data;
      end
    end
  end

  // Hazard is read from the registered scoreboard; x0 never stalls.
  always_comb begin
    hazard = (busy_q[query_rs1] && (query_rs1 != '0)) ||
             (busy_q[query_rs2] && (query_rs2 != '0));
  end

  assign wr_en   = wr_en_p1;
  assign wr_reg  = wr_reg_p1;
  assign wr_data = wr_data_p1;
  assign busy    = busy_q;

`ifdef RF_WB_TRACE_EN
  logic wr_src_p1;

  function automatic string get_reg_name(input logic [REGISTER_WIDTH-1:0] r);
    case (int'(r))
      0: return "zero";  1: return "ra";   2: return "sp";   3: return "gp";
      4: return "tp";    5: return "t0";   6: return "t1";   7: return "t2";
      8: return "s0";    9: return "s1";   10: return "a0";  11: return "a1";
      12: return "a2";   13: return "a3";  14: return "a4";  15: return "a5";
      16: return "a6";   17: return "a7";  18: return "s2";  19: return "s3";
      20: return "s4";   21: return "s5";  22: return "s6";  23: return "s7";
      24: return "s8";   25: return "s9";  26: return "s10"; 27: return "s11";
      28: return "t3";   29: return "t4";  30: return "t5";  31: return "t6";
      default: return "x?";
    endcase
  endfunction

  // Remember which requester produced the write currently on the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_src_p1 <= 1'b0;
    end else if (acc0_p0 || acc1_p0) begin
      wr_src_p1 <= acc1_p0;
    end
  end

  // Trace completed writes and contested grants.
  always_ff @(posedge clk) begin
    if (!reset && wr_en_p1) begin
      $display("%0t rf_wb: req%0d x%0d (%s) <= %0h", $time, wr_src_p1, wr_reg_p1,
               get_reg_name(wr_reg_p1), wr_data_p1);
    end
    if (!reset && req0_valid && req1_valid) begin
      $display("%0t rf_wb: conflict won by req%0d", $time, acc1_p0 ? 1 : 0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter with a write-port scoreboard.
`default_nettype none

module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_reg = '0;
  logic [63:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_reg = '0;
  logic [63:0] req1_data = '0;
  logic        req1_ready;
  logic        reserve_valid = 1'b0;
  logic [4:0]  reserve_reg = '0;
  logic        flush = 1'b0;
  logic [4:0]  query_rs1 = '0;
  logic [4:0]  query_rs2 = '0;
  logic        hazard;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [63:0] wr_data;
  logic [31:0] busy;

  rf_writeback_arbiter #(.REGISTER_WIDTH(5), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .reserve_valid(reserve_valid), .reserve_reg(reserve_reg), .flush(flush),
    .query_rs1(query_rs1), .query_rs2(query_rs2), .hazard(hazard),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  r;
    logic [63:0] d;
  } wr_t;

  wr_t         sb[$];
  int          tests = 0;
  int          fails = 0;
  logic        m_prio = 1'b0;
  logic [31:0] m_busy = '0;
  logic [4:0]  m_reg = '0;
  logic [63:0] m_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [63:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [63:0] d1,
                       input logic rv, input logic [4:0] rr, input logic fl,
                       input logic [4:0] q1, input logic [4:0] q2);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    reserve_valid = rv; reserve_reg = rr; flush = fl;
    query_rs1 = q1; query_rs2 = q2;
  endtask

  // One clock: check combinational outputs, predict the edge, check results.
  task automatic cycle();
    logic  er0, er1, a0, a1, ehz;
    logic [31:0] nb;
    wr_t   e;
    wr_t   got;
    #1;
    er0 = !req1_valid || (m_prio == 1'b0);
    er1 = !req0_valid || (m_prio == 1'b1);
    ehz = (m_busy[query_rs1] && query_rs1 != 0) || (m_busy[query_rs2] && query_rs2 != 0);
    chk("req0_ready", {63'd0, req0_ready}, {63'd0, er0});
    chk("req1_ready", {63'd0, req1_ready}, {63'd0, er1});
    chk("hazard", {63'd0, hazard}, {63'd0, ehz});
    a0 = req0_valid && er0;
    a1 = req1_valid && er1;
    nb = m_busy;
    if (flush) nb = '0;
    else if (a0) nb[req0_reg] = 1'b0;
    else if (a1) nb[req1_reg] = 1'b0;
    if (reserve_valid && reserve_reg != 0) nb[reserve_reg] = 1'b1;
    if (a0) begin m_reg = req0_reg; m_data = req0_data; m_prio = 1'b1; end
    else if (a1) begin m_reg = req1_reg; m_data = req1_data; m_prio = 1'b0; end
    e.en = (a0 && req0_reg != 0) || (a1 && req1_reg != 0);
    e.r = m_reg;
    e.d = m_data;
    sb.push_back(e);
    m_busy = nb;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk("wr_en", {63'd0, wr_en}, {63'd0, got.en});
      chk("wr_reg", {59'd0, wr_reg}, {59'd0, got.r});
      chk("wr_data", wr_data, got.d);
    end
    chk("busy", {32'd0, busy}, {32'd0, m_busy});
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Power-on reset
    #2;
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_busy", {32'd0, busy}, 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Build busy = 0xFF0, then leave a write in flight and reset mid-cycle
    for (int r = 4; r < 12; r++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 5'(r), 0, 0, 0);
      cycle();
    end
    chk("busy_ff0", {32'd0, busy}, 64'h0000_0ff0);
    drive(1, 12, 64'hABCD, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("pre_rst_wr_en", {63'd0, wr_en}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {32'd0, busy}, 64'd0);
    chk("async_rst_wr_en", {63'd0, wr_en}, 64'd0);
    m_busy = '0; m_prio = 1'b0; m_reg = '0; m_data = '0;
    sb.delete();
    reset = 1'b0;
    @(negedge clk);

    // Both valid from reset: grants alternate 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 64'h300 + 64'(i), 1, 7, 64'h700 + 64'(i), 0, 0, 0, 0, 0);
      #1;
      chk("rr_grant0", {63'd0, req0_ready}, {63'd0, (i % 2 == 0)});
      cycle();
      chk("rr_wr_reg", {59'd0, wr_reg}, (i % 2 == 0) ? 64'd3 : 64'd7);
    end

    // req0 alone to a reserved register
    drive(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    cycle();
    drive(1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 5, 0);
    #1;
    chk("r0_only_ready", {63'd0, req0_ready}, 64'd1);
    cycle();
    chk("r0_only_data", wr_data, 64'h1234);
    chk("busy5_clear", {63'd0, busy[5]}, 64'd0);

    // Hazard tracking on x9
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 9, 64'h99, 0, 0, 0, 0, 9);
    #1;
    chk("hazard_rs2", {63'd0, hazard}, 64'd1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
    #1;
    chk("hazard_cleared", {63'd0, hazard}, 64'd0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 9, 64'h9a, 1, 9, 0, 9, 0);
    cycle();
    chk("set_wins_busy9", {63'd0, busy[9]}, 64'd1);

    // x0 write: accepted, prio flips, no write; x0 reserve ignored
    drive(1, 0, 64'hFF, 0, 0, 0, 1, 0, 0, 0, 0);
    cycle();
    chk("x0_no_wr", {63'd0, wr_en}, 64'd0);
    drive(1, 1, 64'h11, 1, 2, 64'h22, 0, 0, 0, 0, 0);
    #1;
    chk("x0_prio_flip", {63'd0, req1_ready}, 64'd1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("x0_hazard", {63'd0, hazard}, 64'd0);
    cycle();

    // Flush with a same-cycle reserve
    drive(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0);
    cycle();
    chk("flush_only6", {32'd0, busy}, 64'h40);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
